// File: rtl/mips_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_decode_pkg
//  Description : Shared opcode/funct codes, ALU encodings, control bundle type
//                and FSM state type for the MIPS decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_decode_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ANDI  = 6'h0c;
    localparam logic [5:0] c_OP_ORI   = 6'h0d;
    localparam logic [5:0] c_OP_XORI  = 6'h0e;
    localparam logic [5:0] c_OP_LUI   = 6'h0f;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2b;

    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_XOR   = 6'h26;
    localparam logic [5:0] c_FN_NOR   = 6'h27;
    localparam logic [5:0] c_FN_SLT   = 6'h2a;
    localparam logic [5:0] c_FN_SLTU  = 6'h2b;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_NOR = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    localparam logic [1:0] c_SLT_NONE     = 2'b00;
    localparam logic [1:0] c_SLT_SIGNED   = 2'b01;
    localparam logic [1:0] c_SLT_UNSIGNED = 2'b10;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       writeenable;
        logic       rd_src;
        logic       alu_src2;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       branch_ne;
        logic [1:0] slt_op;
        logic       lui_op;
        logic       except;
    } ctrl_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mips_decode_comb.sv
`default_nettype none
// ============================================================================
//  Module      : mips_decode_comb
//  Description : Combinational {opcode,funct} to control-bundle decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_decode_comb
    import mips_decode_pkg::*;
#(
    parameter int EXT_OPS = 1
) (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    localparam bit c_EXT = (EXT_OPS != 0);

    ctrl_t w_ctrl;
    logic  w_illegal;
    logic  w_ext_only;

    always_comb begin
        w_ctrl     = '0;
        w_illegal  = 1'b0;
        w_ext_only = 1'b0;
        case (opcode)
            c_OP_RTYPE: begin
                w_ctrl.writeenable = 1'b1;
                case (funct)
                    c_FN_ADD:  w_ctrl.alu_op = ALU_ADD;
                    c_FN_SUB:  w_ctrl.alu_op = ALU_SUB;
                    c_FN_AND:  w_ctrl.alu_op = ALU_AND;
                    c_FN_OR:   w_ctrl.alu_op = ALU_OR;
                    c_FN_XOR:  w_ctrl.alu_op = ALU_XOR;
                    c_FN_NOR:  w_ctrl.alu_op = ALU_NOR;
                    c_FN_SLT: begin
                        w_ctrl.alu_op = ALU_SUB;
                        w_ctrl.slt_op = c_SLT_SIGNED;
                        w_ext_only    = 1'b1;
                    end
                    c_FN_SLTU: begin
                        w_ctrl.alu_op = ALU_SUB;
                        w_ctrl.slt_op = c_SLT_UNSIGNED;
                        w_ext_only    = 1'b1;
                    end
                    default:   w_illegal = 1'b1;
                endcase
            end
            c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_XORI: begin
                w_ctrl.writeenable = 1'b1;
                w_ctrl.rd_src      = 1'b1;
                w_ctrl.alu_src2    = 1'b1;
                case (opcode)
                    c_OP_ADDI: w_ctrl.alu_op = ALU_ADD;
                    c_OP_ANDI: w_ctrl.alu_op = ALU_AND;
                    c_OP_ORI:  w_ctrl.alu_op = ALU_OR;
                    default:   w_ctrl.alu_op = ALU_XOR;
                endcase
            end
            c_OP_LUI: begin
                w_ctrl.lui_op      = 1'b1;
                w_ctrl.rd_src      = 1'b1;
                w_ctrl.alu_src2    = 1'b1;
                w_ctrl.writeenable = 1'b1;
                w_ext_only         = 1'b1;
            end
            c_OP_LW: begin
                w_ctrl.alu_op      = ALU_ADD;
                w_ctrl.mem_read    = 1'b1;
                w_ctrl.rd_src      = 1'b1;
                w_ctrl.alu_src2    = 1'b1;
                w_ctrl.writeenable = 1'b1;
                w_ext_only         = 1'b1;
            end
            c_OP_SW: begin
                w_ctrl.alu_op    = ALU_ADD;
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src2  = 1'b1;
                w_ext_only       = 1'b1;
            end
            c_OP_BEQ, c_OP_BNE: begin
                w_ctrl.alu_op    = ALU_SUB;
                w_ctrl.branch    = 1'b1;
                w_ctrl.branch_ne = (opcode == c_OP_BNE);
                w_ext_only       = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase

        // Extended encodings fall back to an exception in the base instruction set
        if (w_illegal || (w_ext_only && !c_EXT)) begin
            w_ctrl        = '0;
            w_ctrl.except = 1'b1;
        end
    end

    assign ctrl = w_ctrl;

endmodule
`default_nettype wire

// File: rtl/mips_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mips_decode_stage
//  Description : Handshaked MIPS decode stage: decoder, output FIFO, sticky
//                exception flag/counter and optional halt-on-exception FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_decode_stage
    import mips_decode_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int EXT_OPS     = 1,
    parameter int EXC_CNT_W   = 8,
    parameter int HALT_ON_EXC = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           alu_op,
    output logic                 writeenable,
    output logic                 rd_src,
    output logic                 alu_src2,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 branch,
    output logic                 branch_ne,
    output logic [1:0]           slt_op,
    output logic                 lui_op,
    output logic                 except,
    output logic                 exc_flag,
    output logic [EXC_CNT_W-1:0] exc_count,
    input  logic                 exc_clear
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_OCC_W = $clog2(DEPTH + 1);

    ctrl_t                r_fifo [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_OCC_W-1:0]   r_occ;
    logic                 r_armed;
    logic                 r_exc_flag;
    logic [EXC_CNT_W-1:0] r_exc_count;
    state_t               r_state;
    state_t               w_state_next;

    ctrl_t w_dec;
    ctrl_t w_head;
    logic  w_full;
    logic  w_empty;
    logic  w_push;
    logic  w_pop;
    logic  w_exc_accept;

    mips_decode_comb #(
        .EXT_OPS (EXT_OPS)
    ) u_decode (
        .opcode (opcode),
        .funct  (funct),
        .ctrl   (w_dec)
    );

    assign w_full       = (r_occ == c_OCC_W'(DEPTH));
    assign w_empty      = (r_occ == '0);
    // r_armed holds in_ready low until the first clock edge after reset releases
    assign in_ready     = r_armed && !w_full && (r_state == RUN);
    assign out_valid    = !w_empty;
    assign w_push       = in_valid && in_ready;
    assign w_pop        = out_valid && out_ready;
    assign w_exc_accept = w_push && w_dec.except;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_dec;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_armed  <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // A clear in the same cycle as an excepting accept is applied first
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_exc_flag  <= 1'b0;
            r_exc_count <= '0;
        end else begin
            if (exc_clear) begin
                r_exc_flag  <= 1'b0;
                r_exc_count <= '0;
            end
            if (w_exc_accept) begin
                r_exc_flag <= 1'b1;
                if (exc_clear) begin
                    r_exc_count <= EXC_CNT_W'(1);
                end else if (!(&r_exc_count)) begin
                    r_exc_count <= r_exc_count + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if ((HALT_ON_EXC != 0) && w_exc_accept) w_state_next = HALT;
            HALT:    if (exc_clear) w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    assign w_head      = out_valid ? r_fifo[r_rd_ptr] : '0;
    assign alu_op      = w_head.alu_op;
    assign writeenable = w_head.writeenable;
    assign rd_src      = w_head.rd_src;
    assign alu_src2    = w_head.alu_src2;
    assign mem_read    = w_head.mem_read;
    assign mem_write   = w_head.mem_write;
    assign branch      = w_head.branch;
    assign branch_ne   = w_head.branch_ne;
    assign slt_op      = w_head.slt_op;
    assign lui_op      = w_head.lui_op;
    assign except      = w_head.except;
    assign exc_flag    = r_exc_flag;
    assign exc_count   = r_exc_count;

endmodule
`default_nettype wire
